// File: rtl/pwm_capture.sv
// PWM period / high-time capture for an upstream timer's PWM output.
// Registers are read through a one-cycle-latency select port.
module pwm_capture #(
   parameter int unsigned CW = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_pwm,
   input  logic          i_timer_end,
   input  logic          i_clr,
   input  logic          i_rd,
   input  logic [1:0]    i_raddr,
   output logic [CW-1:0] o_rdata,
   output logic          o_rvalid,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   state_t        state_q;
   state_t        state_d;
   logic          pwm_d;
   logic          rise;
   logic          fall;

   logic [CW-1:0] per_cnt;
   logic [CW-1:0] hi_cnt;
   logic [CW-1:0] pulse_cnt;
   logic [CW-1:0] per_reg;
   logic [CW-1:0] hi_reg;

   logic [CW-1:0] per_cnt_nxt;
   logic [CW-1:0] hi_cnt_nxt;
   logic [CW-1:0] pulse_cnt_nxt;
   logic [CW-1:0] per_reg_nxt;
   logic [CW-1:0] hi_reg_nxt;
   logic          ovf_nxt;
   logic          done_nxt;
   logic          busy_nxt;
   logic [CW-1:0] rdata_nxt;

   logic          per_inc;
   logic          hi_inc;
   logic          pulse_inc;
   logic          latch;
   logic          reload;

   assign rise = i_pwm & ~pwm_d;
   assign fall = ~i_pwm & pwm_d;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; end-of-sequence wins over an edge in the same cycle
   always_comb begin
      state_d = state_q;
      if (i_clr) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: if (rise) state_d = HIGH;
            HIGH: begin
               if (i_timer_end)  state_d = DONE;
               else if (fall)    state_d = LOW;
            end
            LOW: begin
               if (i_timer_end)  state_d = DONE;
               else if (rise)    state_d = HIGH;
            end
            default:             state_d = IDLE;
         endcase
      end
   end

   // Measurement datapath and registered-output next values
   always_comb begin
      per_inc       = 1'b0;
      hi_inc        = 1'b0;
      pulse_inc     = 1'b0;
      latch         = 1'b0;
      reload        = 1'b0;
      per_cnt_nxt   = per_cnt;
      hi_cnt_nxt    = hi_cnt;
      pulse_cnt_nxt = pulse_cnt;
      per_reg_nxt   = per_reg;
      hi_reg_nxt    = hi_reg;
      ovf_nxt       = o_ovf;

      case (state_q)
         IDLE, DONE: begin
            if (rise) begin
               reload        = 1'b1;
               pulse_cnt_nxt = '0;
            end
         end
         HIGH: begin
            if (i_timer_end) begin
               latch     = 1'b1;
               pulse_inc = 1'b1;
            end else begin
               per_inc = 1'b1;
               hi_inc  = i_pwm;
            end
         end
         LOW: begin
            if (rise) begin
               latch     = 1'b1;
               pulse_inc = 1'b1;
               reload    = 1'b1;
            end else if (i_timer_end) begin
               latch     = 1'b1;
               pulse_inc = 1'b1;
            end else begin
               per_inc = 1'b1;
            end
         end
         default: ;
      endcase

      if (latch) begin
         per_reg_nxt = per_cnt;
         hi_reg_nxt  = hi_cnt;
      end
      if (reload) begin
         per_cnt_nxt = CNT_ONE;
         hi_cnt_nxt  = CNT_ONE;
      end

      // Saturating increments; any attempt at the ceiling flags overflow
      if (per_inc) begin
         if (per_cnt == CNT_MAX) ovf_nxt = 1'b1;
         else                    per_cnt_nxt = per_cnt + CNT_ONE;
      end
      if (hi_inc) begin
         if (hi_cnt == CNT_MAX)  ovf_nxt = 1'b1;
         else                    hi_cnt_nxt = hi_cnt + CNT_ONE;
      end
      if (pulse_inc) begin
         if (pulse_cnt == CNT_MAX) ovf_nxt = 1'b1;
         else                      pulse_cnt_nxt = pulse_cnt + CNT_ONE;
      end

      if (i_clr) begin
         per_cnt_nxt   = '0;
         hi_cnt_nxt    = '0;
         pulse_cnt_nxt = '0;
         per_reg_nxt   = '0;
         hi_reg_nxt    = '0;
         ovf_nxt       = 1'b0;
      end

      done_nxt = (state_d == DONE) && (state_q != DONE);
      busy_nxt = (state_d == HIGH) || (state_d == LOW);
   end

   // Read mux samples pre-update state so clear/latch cycles return old values
   always_comb begin
      rdata_nxt = o_rdata;
      if (i_rd) begin
         case (i_raddr)
            2'd0:    rdata_nxt = per_reg;
            2'd1:    rdata_nxt = hi_reg;
            2'd2:    rdata_nxt = pulse_cnt;
            default: rdata_nxt = CW'({state_q, o_ovf, o_busy});
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pwm_d     <= 1'b0;
         per_cnt   <= '0;
         hi_cnt    <= '0;
         pulse_cnt <= '0;
         per_reg   <= '0;
         hi_reg    <= '0;
         o_rdata   <= '0;
         o_rvalid  <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_ovf     <= 1'b0;
      end else begin
         pwm_d     <= i_pwm;
         per_cnt   <= per_cnt_nxt;
         hi_cnt    <= hi_cnt_nxt;
         pulse_cnt <= pulse_cnt_nxt;
         per_reg   <= per_reg_nxt;
         hi_reg    <= hi_reg_nxt;
         o_rdata   <= rdata_nxt;
         o_rvalid  <= i_rd;
         o_busy    <= busy_nxt;
         o_done    <= done_nxt;
         o_ovf     <= ovf_nxt;
      end
   end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CW, default 16, meaning counter and readback data width.
REQ-002 SHALL have port i_clk, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, meaning a synchronous, active-high reset.
REQ-004 SHALL have port i_pwm, input, 1, meaning the PWM output of the upstream timer, in the i_clk domain, not synchronized.
REQ-005 SHALL have port i_timer_end, input, 1, meaning the upstream timer end-of-sequence strobe.
REQ-006 SHALL have port i_clr, input, 1, meaning a clear strobe that returns the block to IDLE.
REQ-007 SHALL have port i_rd, input, 1, meaning a read strobe.
REQ-008 SHALL have port i_raddr, input, 2, meaning the read register select.
REQ-009 SHALL have port o_rdata, output, CW, meaning the registered read data.
REQ-010 SHALL have port o_rvalid, output, 1, meaning o_rdata is valid.
REQ-011 SHALL have port o_busy, output, 1, meaning state is HIGH or LOW.
REQ-012 SHALL have port o_done, output, 1, meaning a one-cycle pulse on entry to DONE.
REQ-013 SHALL have port o_ovf, output, 1, meaning a sticky counter-saturation flag.

Function
REQ-014 SHALL register i_pwm into pwm_d and define the edge terms as: rise = i_pwm & ~pwm_d; fall = ~i_pwm & pwm_d.
REQ-015 SHALL implement states IDLE, HIGH, LOW, DONE.
REQ-016 SHALL, on rise in IDLE or DONE, set per_cnt=1, hi_cnt=1 and pulse_cnt=0, and enter HIGH.
REQ-017 SHALL, in HIGH, increment per_cnt every cycle, increment hi_cnt while i_pwm=1, and on fall enter LOW without incrementing hi_cnt.
REQ-018 SHALL, in LOW, increment per_cnt every cycle except the rise cycle.
REQ-019 SHALL, on rise in LOW, latch PER_REG=per_cnt and HI_REG=hi_cnt, increment pulse_cnt, reload per_cnt=1 and hi_cnt=1, and enter HIGH.
REQ-020 SHALL, on i_timer_end in HIGH or LOW, latch PER_REG=per_cnt and HI_REG=hi_cnt as they stand (current cycle excluded), increment pulse_cnt, enter DONE, and pulse o_done the following cycle.
REQ-021 SHALL, when rise and i_timer_end coincide in LOW, perform the REQ-019 latch and then enter DONE instead of HIGH (one pulse_cnt increment only).
REQ-022 SHALL ignore i_timer_end in IDLE and DONE.
REQ-023 SHALL ignore fall in LOW and rise in HIGH, since these cannot occur.
REQ-024 SHALL make per_cnt, hi_cnt and pulse_cnt saturate at 2^CW-1 (no wrap), and set o_ovf on any increment attempted at saturation.
REQ-025 SHALL keep o_ovf set until i_clr or i_rst.
REQ-026 SHALL, on i_clr (priority over all except i_rst), enter IDLE, zero all counters and registers, and clear o_ovf; an in-progress measurement is discarded.
REQ-027 SHALL, on i_rd in cycle t, drive o_rdata and o_rvalid=1 in cycle t+1; o_rvalid=0 otherwise.
REQ-028 SHALL decode the read map as: 0 = PER_REG; 1 = HI_REG; 2 = pulse_cnt; 3 = status {zero-fill, state[1:0], o_ovf, o_busy} with IDLE=0, HIGH=1, LOW=2, DONE=3.
REQ-029 SHALL, when i_rd and i_clr coincide, return pre-clear values.
REQ-030 SHALL, when i_rd coincides with a latch event, return pre-latch values.

Reset
REQ-031 SHALL, on i_rst=1 at a clock edge, set state to IDLE, zero pwm_d, all counters, PER_REG, HI_REG and o_rdata, and drive o_rvalid=0, o_busy=0, o_done=0, o_ovf=0.
REQ-032 SHALL, while i_rst=1, ignore i_rd, i_clr, i_pwm and i_timer_end.
REQ-033 SHALL, on reset mid-measurement, abort and require a fresh rise.

Verification
REQ-034 SHALL cover: PWM period 20 and high 10 for 3 periods, then i_timer_end at the end of the 3rd low phase -> PER_REG=20, HI_REG=10, pulse_cnt=3, one o_done pulse.
REQ-035 SHALL cover: rise coinciding with i_timer_end in LOW after 2 periods of 20/10 -> pulse_cnt=2, state DONE, PER_REG=20.
REQ-036 SHALL cover: i_pwm held high 70000 cycles -> hi_cnt and per_cnt at 0xFFFF and o_ovf=1; after i_clr -> o_ovf=0, status reads 0.
REQ-037 SHALL cover: i_clr asserted mid-HIGH -> IDLE, o_busy=0, and a subsequent rise restarts with pulse_cnt=0.
REQ-038 SHALL cover: i_rd with i_raddr=1 in cycle t -> o_rvalid=1 and o_rdata=HI_REG in cycle t+1 only.
REQ-039 SHALL cover: i_rst asserted in LOW -> all outputs 0 next cycle; i_timer_end afterwards -> no o_done.
